// File: rtl/fifo_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
//   Shared definitions for the two-producer fifo write-port arbiter.
//   - arb_state_e : arbiter state encoding. The owner output reuses it, so
//                   2'b00 = idle, 2'b01 = producer 0, 2'b10 = producer 1.
//   - STALL_W     : width of the optional per-producer stall counters.
//   - sat_inc     : saturating increment used by the stall counters.
// -----------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_OWN0 = 2'b01,
        ARB_OWN1 = 2'b10
    } arb_state_e;

    localparam int STALL_W = 16;

    // Stops at all-ones instead of wrapping back to zero.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == {STALL_W{1'b1}}) ? v : v + STALL_W'(1);
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// fifo_arb_rr_pick
//   Two-way round-robin picker, purely combinational.
//   Ports:
//     req0, req1 : in  - candidate requests
//     last_srv   : in  - producer that was served last (0/1); loses a tie
//     pick       : out - chosen producer (0/1), meaningful when valid=1
//     valid      : out - at least one request present
// -----------------------------------------------------------------------------
module fifo_arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_srv,
    output logic pick,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        // On a tie the producer that was not served last wins; otherwise the
        // only requester wins (req1 alone -> 1, req0 alone or none -> 0).
        pick  = (req0 & req1) ? ~last_srv : req1;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares one fifo write port between two producers with round-robin
//   ownership and bounded bursts. An owner streams up to BURST_LEN accepted
//   beats, then hands over if the other producer is waiting; with the other
//   producer silent the owner keeps streaming indefinitely. Every ownership
//   starts with one idle bubble cycle coming out of IDLE; owner-to-owner
//   handovers have no bubble.
//
//   Parameters:
//     DW        : data width (producer and fifo)
//     BURST_LEN : max accepted beats per ownership while the other requests (>=1)
//     CNT_W     : burst counter width, 2**CNT_W > BURST_LEN
//
//   Ports:
//     clk              : rising-edge clock
//     rst              : synchronous active-high reset
//     req0/req1        : producer has a beat on data0/data1, held until granted
//     data0/data1      : producer data
//     gnt0/gnt1        : beat accepted from that producer this cycle (comb.)
//     fifo_full        : fifo full flag; blocks grants, never forces a switch
//     fifo_wr/fifo_din : fifo write enable / data, zero latency from the grant
//     owner            : registered state, 00 idle, 01 producer 0, 10 producer 1
//     stall0/stall1    : cycles a producer requested without a grant
//
//   Build option: define ARB_STATS_EN to build the saturating stall counters.
//   Without it stall0/stall1 are tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DW        = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [DW-1:0]      data0,
    output logic               gnt0,
    input  logic               req1,
    input  logic [DW-1:0]      data1,
    output logic               gnt1,
    input  logic               fifo_full,
    output logic               fifo_wr,
    output logic [DW-1:0]      fifo_din,
    output logic [1:0]         owner,
    output logic [STALL_W-1:0] stall0,
    output logic [STALL_W-1:0] stall1
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    arb_state_e       state_q, state_d;
    logic             last_srv_q, last_srv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       pick_req0, pick_req1;
    logic       pick, pick_valid;
    arb_state_e pick_state;
    logic       own_req;
    logic       beat;
    logic       burst_done;

    // -------------------------------------------------------------------------
    // Picker. One instance serves both decisions: in IDLE it sees both
    // requests; in OWNx the owner's own request is masked, so it answers
    // "is the other producer waiting?" and points at it.
    // -------------------------------------------------------------------------
    assign pick_req0 = req0 & (state_q != ARB_OWN0);
    assign pick_req1 = req1 & (state_q != ARB_OWN1);

    fifo_arb_rr_pick u_pick (
        .req0     (pick_req0),
        .req1     (pick_req1),
        .last_srv (last_srv_q),
        .pick     (pick),
        .valid    (pick_valid)
    );

    assign pick_state = pick ? ARB_OWN1 : ARB_OWN0;

    // -------------------------------------------------------------------------
    // Grants and write port. Grants are suppressed during reset so a beat
    // that would be granted in the reset cycle is never written.
    // -------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        gnt0     = ~rst & (state_q == ARB_OWN0) & req0 & ~fifo_full;
        gnt1     = ~rst & (state_q == ARB_OWN1) & req1 & ~fifo_full;
        fifo_wr  = gnt0 | gnt1;
        fifo_din = '0;
        if (gnt0) begin
            fifo_din = data0;
        end else if (gnt1) begin
            fifo_din = data1;
        end
    end

    // Grants already include the request, so any grant is an accepted beat.
    assign beat       = gnt0 | gnt1;
    assign own_req    = (state_q == ARB_OWN0) ? req0 : req1;
    assign burst_done = (cnt_q + CNT_W'(1)) == CNT_W'(BURST_LEN);

    // -------------------------------------------------------------------------
    // Next-state logic. Release conditions are checked in priority order:
    // owner's request gone, then burst length reached, then plain counting.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_srv_d = last_srv_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            ARB_IDLE: begin
                // Entering ownership costs one bubble: no grants in IDLE.
                if (pick_valid) begin
                    state_d = pick_state;
                end
            end

            ARB_OWN0, ARB_OWN1: begin
                if (!own_req) begin
                    // Owner went quiet: hand over or fall back to IDLE, and
                    // remember who was served so the next tie goes the other way.
                    state_d    = pick_valid ? pick_state : ARB_IDLE;
                    cnt_d      = '0;
                    last_srv_d = (state_q == ARB_OWN1);
                end else if (beat) begin
                    if (burst_done) begin
                        // Burst complete: yield only if the other side waits,
                        // otherwise keep streaming with a fresh burst.
                        cnt_d = '0;
                        if (pick_valid) begin
                            state_d = pick_state;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // No beat (fifo full): counter and ownership hold.
            end

            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            last_srv_q <= 1'b1;     // producer 0 wins the first tie
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_srv_q <= last_srv_d;
            cnt_q      <= cnt_d;
        end
    end

    assign owner = state_q;

    // -------------------------------------------------------------------------
    // Optional stall statistics: count every requesting cycle without a
    // grant, including the IDLE bubble and fifo-full cycles.
    // -------------------------------------------------------------------------
`ifdef ARB_STATS_EN
    logic [STALL_W-1:0] stall0_q, stall0_d;
    logic [STALL_W-1:0] stall1_q, stall1_d;

    always_comb begin
        stall0_d = stall0_q;
        stall1_d = stall1_q;
        if (req0 && !gnt0) begin
            stall0_d = sat_inc(stall0_q);
        end
        if (req1 && !gnt1) begin
            stall1_d = sat_inc(stall1_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall0_q <= '0;
            stall1_q <= '0;
        end else begin
            stall0_q <= stall0_d;
            stall1_q <= stall1_d;
        end
    end

    assign stall0 = stall0_q;
    assign stall1 = stall1_q;
`else
    assign stall0 = '0;
    assign stall1 = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter. A behavioural policy model
//   (owner, last served, beats in current burst, stall counts) predicts the
//   outputs every cycle; directed scenarios add explicit expected constants.
//   Inputs change just after the rising edge; outputs are compared on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int BL = 4;
    localparam int VW = 45;   // {gnt0,gnt1,fifo_wr,fifo_din[7:0],owner[1:0],stall0,stall1}

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, fifo_full;
    logic [DW-1:0] data0, data1;
    logic          gnt0, gnt1, fifo_wr;
    logic [DW-1:0] fifo_din;
    logic [1:0]    owner;
    logic [15:0]   stall0, stall1;
    logic [VW-1:0] obs_vec;
    logic [VW-1:0] exp_v;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner 0 idle / 1 producer 0 / 2 producer 1.
    int m_owner = 0;
    int m_last  = 1;
    int m_cnt   = 0;
    int m_s0    = 0;
    int m_s1    = 0;

    fifo_wr_arbiter #(.DW(DW), .BURST_LEN(BL), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .gnt0      (gnt0),
        .req1      (req1),
        .data1     (data1),
        .gnt1      (gnt1),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .owner     (owner),
        .stall0    (stall0),
        .stall1    (stall1)
    );

    always #5 clk = ~clk;

    assign obs_vec = {gnt0, gnt1, fifo_wr, fifo_din, owner, stall0, stall1};

    // Expected outputs for the current cycle from model state and inputs.
    function automatic logic [VW-1:0] exp_vec();
        logic          g0, g1;
        logic [DW-1:0] d;
        logic [15:0]   s0, s1;
        g0 = !rst && m_owner == 1 && req0 && !fifo_full;
        g1 = !rst && m_owner == 2 && req1 && !fifo_full;
        d  = g0 ? data0 : (g1 ? data1 : 8'h00);
`ifdef ARB_STATS_EN
        s0 = 16'(m_s0);
        s1 = 16'(m_s1);
`else
        s0 = 16'h0000;
        s1 = 16'h0000;
`endif
        return {g0, g1, g0 | g1, d, 2'(m_owner), s0, s1};
    endfunction

    // Apply the arbitration rules for the coming clock edge.
    task automatic model_step();
        bit g0, g1, mine, oth;
        int other;
        g0 = !rst && m_owner == 1 && req0 && !fifo_full;
        g1 = !rst && m_owner == 2 && req1 && !fifo_full;
        if (rst) begin
            m_owner = 0; m_last = 1; m_cnt = 0; m_s0 = 0; m_s1 = 0;
            return;
        end
        if (req0 && !g0 && m_s0 < 65535) m_s0++;
        if (req1 && !g1 && m_s1 < 65535) m_s1++;
        if (m_owner == 0) begin
            if (req0 && req1)  m_owner = (m_last == 1) ? 1 : 2;
            else if (req0)     m_owner = 1;
            else if (req1)     m_owner = 2;
        end else begin
            mine  = (m_owner == 1) ? req0 : req1;
            oth   = (m_owner == 1) ? req1 : req0;
            other = 3 - m_owner;
            if (!mine) begin
                m_last  = m_owner - 1;
                m_owner = oth ? other : 0;
                m_cnt   = 0;
            end else if (g0 || g1) begin
                m_cnt++;
                if (m_cnt == BL) begin
                    m_cnt = 0;
                    if (oth) m_owner = other;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; fifo_full = 1'b0;
        data0 = '0; data1 = '0;
        tick();
        rst = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; fifo_full = 1'b0;
        data0 = 8'hA5; data1 = 8'h5A;
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt0, gnt1, fifo_wr, owner} !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_cyc%0d: got gnt0/gnt1/wr/owner=%b want 00000", i,
                         {gnt0, gnt1, fifo_wr, owner});
            end
            if (i == 0) tick();
        end
        rst = 1'b0;
        tick();
        @(negedge clk);
        exp_v = exp_vec();
        n_cmp++;
        if (obs_vec !== exp_v) begin
            n_bad++;
            $display("FAIL reset_release_model: got %h want %h", obs_vec, exp_v);
        end
        n_cmp++;
        if (owner !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_release_owner: got %b want 01", owner);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single();
        do_reset();
        req0 = 1'b1; req1 = 1'b0; data0 = 8'h00;
        @(negedge clk);
        n_cmp++;
        if ({fifo_wr, owner} !== 3'b000) begin
            n_bad++;
            $display("FAIL single_bubble: got wr/owner=%b want 000", {fifo_wr, owner});
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            data0 = 8'(i);
            @(negedge clk);
            exp_v = exp_vec();
            n_cmp++;
            if (obs_vec !== exp_v) begin
                n_bad++;
                $display("FAIL single_model beat%0d: got %h want %h", i, obs_vec, exp_v);
            end
            n_cmp++;
            if ({fifo_wr, fifo_din, owner} !== {1'b1, 8'(i), 2'b01}) begin
                n_bad++;
                $display("FAIL single_beat%0d: got wr/din/owner=%b/%h/%b want 1/%h/01",
                         i, fifo_wr, fifo_din, owner, 8'(i));
            end
            tick();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_contention();
        logic [1:0] want;
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        tick();   // IDLE bubble
        for (int i = 0; i < 12; i++) begin
            data0 = 8'($urandom); data1 = 8'($urandom);
            want = ((i / BL) % 2 == 0) ? 2'b10 : 2'b01;
            @(negedge clk);
            exp_v = exp_vec();
            n_cmp++;
            if (obs_vec !== exp_v) begin
                n_bad++;
                $display("FAIL contention_model cyc%0d: got %h want %h", i, obs_vec, exp_v);
            end
            n_cmp++;
            if ({gnt0, gnt1} !== want) begin
                n_bad++;
                $display("FAIL contention_gnt cyc%0d: got %b want %b", i, {gnt0, gnt1}, want);
            end
            tick();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_full_stall();
        logic [3:0] want;   // {gnt0,gnt1,owner}
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            fifo_full = (i >= 2 && i <= 6);
            data0 = 8'($urandom); data1 = 8'($urandom);
            if (i >= 2 && i <= 6) want = 4'b0001;
            else if (i == 9)      want = 4'b0110;
            else                  want = 4'b1001;
            @(negedge clk);
            exp_v = exp_vec();
            n_cmp++;
            if (obs_vec !== exp_v) begin
                n_bad++;
                $display("FAIL full_model cyc%0d: got %h want %h", i, obs_vec, exp_v);
            end
            n_cmp++;
            if ({gnt0, gnt1, owner} !== want) begin
                n_bad++;
                $display("FAIL full_stall cyc%0d: got gnt0/gnt1/owner=%b want %b",
                         i, {gnt0, gnt1, owner}, want);
            end
            tick();
        end
        fifo_full = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_req_drop();
        logic [3:0] want;
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        // cyc0: one p0 beat; cyc1: req0 dropped; cyc2..5: p1 burst; cyc6: p0;
        // cyc7: both dropped while p0 owns; cyc8: idle.
        for (int i = 0; i < 9; i++) begin
            req0 = !(i == 1 || i >= 7);
            req1 = (i < 7);
            data0 = 8'($urandom); data1 = 8'($urandom);
            case (i)
                0, 6:    want = 4'b1001;
                1, 7:    want = 4'b0001;
                8:       want = 4'b0000;
                default: want = 4'b0110;
            endcase
            @(negedge clk);
            exp_v = exp_vec();
            n_cmp++;
            if (obs_vec !== exp_v) begin
                n_bad++;
                $display("FAIL drop_model cyc%0d: got %h want %h", i, obs_vec, exp_v);
            end
            n_cmp++;
            if ({gnt0, gnt1, owner} !== want) begin
                n_bad++;
                $display("FAIL req_drop cyc%0d: got gnt0/gnt1/owner=%b want %b",
                         i, {gnt0, gnt1, owner}, want);
            end
            tick();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_stats();
        logic [31:0] want;
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin   // bubble + 4 p0 beats
            @(negedge clk);
            exp_v = exp_vec();
            n_cmp++;
            if (obs_vec !== exp_v) begin
                n_bad++;
                $display("FAIL stats_model cyc%0d: got %h want %h", i, obs_vec, exp_v);
            end
            tick();
        end
`ifdef ARB_STATS_EN
        want = {16'd1, 16'd5};
`else
        want = 32'd0;
`endif
        @(negedge clk);
        n_cmp++;
        if ({stall0, stall1} !== want) begin
            n_bad++;
            $display("FAIL stats_count: got stall0/stall1=%0d/%0d want %0d/%0d",
                     stall0, stall1, want[31:16], want[15:0]);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random();
        bit g0, g1;
        do_reset();
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            exp_v = exp_vec();
            g0 = exp_v[VW-1];
            g1 = exp_v[VW-2];
            n_cmp++;
            if (obs_vec !== exp_v) begin
                n_bad++;
                $display("FAIL random cyc%0d: got %h want %h", i, obs_vec, exp_v);
            end
            tick();
            rst       = ($urandom_range(0, 59) == 0);
            fifo_full = ($urandom_range(0, 4) == 0);
            // Producers mostly hold a pending request; occasional drops exercise
            // the release-on-drop rule.
            if (!(req0 && !g0 && $urandom_range(0, 19) != 0)) begin
                req0  = ($urandom_range(0, 2) != 0);
                data0 = 8'($urandom);
            end
            if (!(req1 && !g1 && $urandom_range(0, 19) != 0)) begin
                req1  = ($urandom_range(0, 2) != 0);
                data1 = 8'($urandom);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full_stall();
        test_req_drop();
        test_stats();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
